// File: rtl/serial_add_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl.
// Optional macro SERIAL_ADD_SUB_EN adds the sub select line.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/fa_cell.sv
// Single-bit full adder, purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder step per clock, LSB first.
// Result appears WIDTH cycles after the accepted start, with a one-cycle
// done pulse; a start during that DONE cycle chains the next operation.
// Optional macro SERIAL_ADD_SUB_EN enables subtraction (a + ~b + 1).
//
// state | meaning
// IDLE  | waiting for start, sum/cout hold last result
// RUN   | one result bit per cycle, busy high
// DONE  | result valid, done high for one cycle
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_c;
  logic             sub_sel;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // Sequencing: operand capture, serial shift, result publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            // Subtraction reuses the adder: invert B and force carry-in.
            b_sh  <= sub_sel ? ~bus.b : bus.b;
            carry <= sub_sel ? 1'b1 : bus.cin;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {fa_s, res[WIDTH-1:1]};
          carry <= fa_c;
          if (cnt == LAST) begin
            state  <= DONE;
            sum_q  <= {fa_s, res[WIDTH-1:1]};
            cout_q <= fa_c;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   pass_cnt = 0;
  int   total    = 0;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic sv);
    bus.a   = av;
    bus.b   = bv;
    bus.cin = cv;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sv;
`else
    if (sv) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
  endtask

  // Issue one start at the next edge and wait (bounded) for done.
  // lat = cycles from start edge to done (-1 if never), bcnt = busy cycles.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic sv,
                       output int lat, output int bcnt, output logic b0);
    int i;
    drive(av, bv, cv, sv);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    b0   = bus.busy;
    bcnt = bus.busy ? 1 : 0;
    lat  = -1;
    i    = 0;
    while (lat < 0 && i < 20) begin
      i++;
      tick();
      if (bus.done) lat = i;
      else if (bus.busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
    total++; if (bus.sum !== 8'h00) $display("FAIL reset_sum got %h want 00", bus.sum); else pass_cnt++;
    total++; if (bus.cout !== 1'b0) $display("FAIL reset_cout got %b want 0", bus.cout); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic b0;
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, lat, bcnt, b0);
    total++; if (b0 !== 1'b1) $display("FAIL basic_busy_at_start got %b want 1", b0); else pass_cnt++;
    total++; if (lat !== 8) $display("FAIL basic_latency got %0d want 8", lat); else pass_cnt++;
    total++; if (bcnt !== 8) $display("FAIL basic_busy_cycles got %0d want 8", bcnt); else pass_cnt++;
    total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", bus.busy); else pass_cnt++;
    total++; if (bus.sum !== 8'h10) $display("FAIL basic_sum got %h want 10", bus.sum); else pass_cnt++;
    total++; if (bus.cout !== 1'b0) $display("FAIL basic_cout got %b want 0", bus.cout); else pass_cnt++;
    tick();
    total++; if (bus.done !== 1'b0) $display("FAIL basic_done_one_cycle got %b want 0", bus.done); else pass_cnt++;
    total++; if (bus.sum !== 8'h10) $display("FAIL basic_sum_hold got %h want 10", bus.sum); else pass_cnt++;
  endtask

  task automatic test_carry();
    int lat, bcnt;
    logic b0;
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt, b0);
    total++; if (lat !== 8) $display("FAIL carry1_latency got %0d want 8", lat); else pass_cnt++;
    total++; if (bus.sum !== 8'h00) $display("FAIL carry1_sum got %h want 00", bus.sum); else pass_cnt++;
    total++; if (bus.cout !== 1'b1) $display("FAIL carry1_cout got %b want 1", bus.cout); else pass_cnt++;
    tick();
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bcnt, b0);
    total++; if (bus.sum !== 8'hFF) $display("FAIL carry2_sum got %h want ff", bus.sum); else pass_cnt++;
    total++; if (bus.cout !== 1'b1) $display("FAIL carry2_cout got %b want 1", bus.cout); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic b0;
    do_op(8'h20, 8'h02, 1'b0, 1'b0, lat, bcnt, b0);
    total++; if (bus.sum !== 8'h22) $display("FAIL b2b_first_sum got %h want 22", bus.sum); else pass_cnt++;
    // Still in the DONE cycle: next start is accepted at this very edge.
    do_op(8'h03, 8'h04, 1'b0, 1'b0, lat, bcnt, b0);
    total++; if (b0 !== 1'b1) $display("FAIL b2b_no_gap_busy got %b want 1", b0); else pass_cnt++;
    total++; if (lat !== 8) $display("FAIL b2b_latency got %0d want 8", lat); else pass_cnt++;
    total++; if (bus.sum !== 8'h07) $display("FAIL b2b_second_sum got %h want 07", bus.sum); else pass_cnt++;
    tick();
  endtask

  task automatic test_ignore_start();
    int lat;
    int i;
    drive(8'h10, 8'h20, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    drive(8'hFF, 8'hFF, 1'b1, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++; if (bus.sum !== 8'h07) $display("FAIL ign_sum_hold_in_run got %h want 07", bus.sum); else pass_cnt++;
    lat = -1;
    i   = 3;
    while (lat < 0 && i < 20) begin
      i++;
      tick();
      if (bus.done) lat = i;
    end
    total++; if (lat !== 8) $display("FAIL ign_latency got %0d want 8", lat); else pass_cnt++;
    total++; if (bus.sum !== 8'h30) $display("FAIL ign_sum got %h want 30", bus.sum); else pass_cnt++;
    total++; if (bus.cout !== 1'b0) $display("FAIL ign_cout got %b want 0", bus.cout); else pass_cnt++;
    tick();
    total++; if (bus.busy !== 1'b0) $display("FAIL ign_no_restart got %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    int dcnt;
    logic b0;
    drive(8'h55, 8'h11, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    // 4th RUN cycle: reset together with a competing start.
    rst_n     = 1'b0;
    bus.start = 1'b1;
    drive(8'hFF, 8'hFF, 1'b1, 1'b0);
    tick();
    rst_n     = 1'b1;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", bus.busy); else pass_cnt++;
    total++; if (bus.sum !== 8'h00) $display("FAIL rst_mid_sum got %h want 00", bus.sum); else pass_cnt++;
    total++; if (bus.cout !== 1'b0) $display("FAIL rst_mid_cout got %b want 0", bus.cout); else pass_cnt++;
    dcnt = bus.done ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) dcnt++;
    end
    total++; if (dcnt !== 0) $display("FAIL rst_mid_no_done got %0d pulses want 0", dcnt); else pass_cnt++;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, lat, bcnt, b0);
    total++; if (lat !== 8) $display("FAIL rst_fresh_latency got %0d want 8", lat); else pass_cnt++;
    total++; if (bus.sum !== 8'h02) $display("FAIL rst_fresh_sum got %h want 02", bus.sum); else pass_cnt++;
    tick();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int lat, bcnt;
    logic b0;
    do_op(8'h05, 8'h07, 1'b0, 1'b1, lat, bcnt, b0);
    total++; if (bus.sum !== 8'hFE) $display("FAIL sub1_sum got %h want fe", bus.sum); else pass_cnt++;
    total++; if (bus.cout !== 1'b0) $display("FAIL sub1_cout got %b want 0", bus.cout); else pass_cnt++;
    tick();
    do_op(8'h07, 8'h05, 1'b0, 1'b1, lat, bcnt, b0);
    total++; if (bus.sum !== 8'h02) $display("FAIL sub2_sum got %h want 02", bus.sum); else pass_cnt++;
    total++; if (bus.cout !== 1'b1) $display("FAIL sub2_cout got %b want 1", bus.cout); else pass_cnt++;
    tick();
    drive(8'h00, 8'h00, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
